sipo_lsb_rx: RTL and testbench

//  Serial-in/parallel-out receiver; downstream partner of the LSB-first PISO serializer.

---
 rtl/sipo_pkg.sv | 10 +
 rtl/sipo_lsb_rx_if.sv | 25 ++
 rtl/bit_cntr.sv | 31 +++
 rtl/sipo_lsb_rx.sv | 126 ++++++++++++
 tb/tb_sipo_lsb_rx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the LSB-first serial-to-parallel receiver.
package sipo_pkg;

  typedef enum logic {IDLE, SHIFT} sipo_state_e;

  function automatic int cnt_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/sipo_lsb_rx_if.sv
// Serial input, handshake and status bundle between a producer/consumer and the receiver.
interface sipo_lsb_rx_if #(parameter int DW = 4);

  logic          enb;
  logic          start;
  logic          inp;
  logic          ack;
  logic          clr;
  logic [DW-1:0] data;
  logic          vld;
  logic          busy;
  logic          ovr;
  logic          abrt;

  modport master (
    output enb, start, inp, ack, clr,
    input  data, vld, busy, ovr, abrt
  );

  modport slave (
    input  enb, start, inp, ack, clr,
    output data, vld, busy, ovr, abrt
  );

endinterface

// File: rtl/bit_cntr.sv
// Bit-position counter for one frame: load-to-1 on a start bit, clear on word completion.
module bit_cntr #(
  parameter int DW    = 4,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_load,
  input  logic i_clr,
  output logic o_term
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over clear so a start bit always begins a fresh count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(1);
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_term = (r_cnt == CNT_W'(DW - 1));

endmodule

// File: rtl/sipo_lsb_rx.sv
// LSB-first serial receiver: frames DW-bit words on a start strobe and presents them
// with a valid/ack handshake plus sticky overrun and abort flags.
module sipo_lsb_rx
  import sipo_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic         clk,
  input  logic         rst,
  sipo_lsb_rx_if.slave bus
);

  localparam int CNT_W = cnt_w(DW);

  sipo_state_e   r_state;
  sipo_state_e   w_nextState;
  logic [DW-1:0] r_sr;
  logic [DW-1:0] r_data;
  logic          r_vld;
  logic          r_ovr;
  logic          r_abrt;

  logic [DW-1:0] w_word;
  logic          w_term;
  logic          w_shift;
  logic          w_load;
  logic          w_inc;
  logic          w_cntClr;
  logic          w_complete;
  logic          w_setAbrt;
  logic          w_setOvr;

  assign w_word = {bus.inp, r_sr[DW-1:1]};

  bit_cntr #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_bitCntr (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_inc),
    .i_load (w_load),
    .i_clr  (w_cntClr),
    .o_term (w_term)
  );

  always_comb begin
    w_nextState = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_cntClr    = 1'b0;
    w_complete  = 1'b0;
    w_setAbrt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enb && bus.start) begin
          w_shift     = 1'b1;
          w_load      = 1'b1;
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.enb) begin
          w_shift = 1'b1;
          // A start mid-frame restarts the frame; stale bits shift out unseen
          if (bus.start) begin
            w_setAbrt = 1'b1;
            w_load    = 1'b1;
          end else if (w_term) begin
            w_complete  = 1'b1;
            w_cntClr    = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_setOvr = w_complete && r_vld && !bus.ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_shift) begin
        r_sr <= w_word;
      end
    end
  end

  // A word completing while the consumer acks in the same cycle replaces it seamlessly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (w_complete && (!r_vld || bus.ack)) begin
      r_data <= w_word;
      r_vld  <= 1'b1;
    end else if (r_vld && bus.ack) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr  <= 1'b0;
      r_abrt <= 1'b0;
    end else begin
      r_ovr  <= w_setOvr  | (r_ovr  & ~bus.clr);
      r_abrt <= w_setAbrt | (r_abrt & ~bus.clr);
    end
  end

  assign bus.data = r_data;
  assign bus.vld  = r_vld;
  assign bus.busy = (r_state == SHIFT);
  assign bus.ovr  = r_ovr;
  assign bus.abrt = r_abrt;

endmodule

// File: tb/tb_sipo_lsb_rx.sv
// Scoreboard bench for sipo_lsb_rx (DW=4): directed frames queue expected words, a
// negedge monitor pops them whenever the DUT hands over a word (vld & ack).
module tb_sipo_lsb_rx;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;

  int nCompared   = 0;
  int nMismatched = 0;
  int nPopped     = 0;
  int loopStart   = 0;

  logic [DW-1:0] expQ[$];

  always #5 clk = ~clk;

  sipo_lsb_rx_if #(.DW(DW)) bus ();

  sipo_lsb_rx #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; one call spans one clock
  task automatic applyStimulus(input logic e, input logic s, input logic i,
                               input logic a, input logic c);
    bus.enb   = e;
    bus.start = s;
    bus.inp   = i;
    bus.ack   = a;
    bus.clr   = c;
    @(posedge clk);
    #2;
  endtask

  // ackMode: 0 = never, 1 = on the last bit only, 2 = every cycle
  task automatic sendFrame(input logic [DW-1:0] v, input int gap, input int ackMode);
    logic a;
    for (int i = 0; i < DW; i++) begin
      a = (ackMode == 2) || ((ackMode == 1) && (i == DW - 1));
      applyStimulus(1'b1, i == 0, v[i], a, 1'b0);
      if (i < DW - 1 && gap > 0) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'b1, ~v[i], ackMode == 2, 1'b0);
        end
        checkOutput("busy held in gap", bus.busy, 1);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] expWord;
    if (rst === 1'b1 && bus.vld === 1'b1 && bus.ack === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected word: got 0x%0h, expected none (t=%0t)", bus.data, $time);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("scoreboard data", bus.data, expWord);
        nPopped++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    bus.enb   = 1'b0;
    bus.start = 1'b0;
    bus.inp   = 1'b0;
    bus.ack   = 1'b0;
    bus.clr   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset data", bus.data, 0);
    checkOutput("reset vld",  bus.vld,  0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset ovr",  bus.ovr,  0);
    checkOutput("reset abrt", bus.abrt, 0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("idle ignores bits busy", bus.busy, 0);
    checkOutput("idle ignores bits vld",  bus.vld,  0);

    $display("[TB] test 1: basic frame 0xA");
    expQ.push_back(4'hA);
    sendFrame(4'hA, 0, 0);
    checkOutput("t1 data", bus.data, 4'hA);
    checkOutput("t1 vld",  bus.vld,  1);
    checkOutput("t1 busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1 vld after ack",  bus.vld,  0);
    checkOutput("t1 data after ack", bus.data, 4'hA);

    $display("[TB] test 2: frame 0x5 with enb gaps");
    expQ.push_back(4'h5);
    sendFrame(4'h5, 3, 0);
    checkOutput("t2 data", bus.data, 4'h5);
    checkOutput("t2 vld",  bus.vld,  1);
    checkOutput("t2 busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2 vld after ack", bus.vld, 0);

    $display("[TB] test 3: overrun");
    expQ.push_back(4'h3);
    sendFrame(4'h3, 0, 0);
    checkOutput("t3 first data", bus.data, 4'h3);
    sendFrame(4'hC, 0, 0);
    checkOutput("t3 data kept", bus.data, 4'h3);
    checkOutput("t3 vld kept",  bus.vld,  1);
    checkOutput("t3 ovr set",   bus.ovr,  1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3 ovr cleared", bus.ovr,  0);
    checkOutput("t3 data still",  bus.data, 4'h3);
    expQ.push_back(4'hC);
    sendFrame(4'hC, 0, 1);
    checkOutput("t3 data replaced", bus.data, 4'hC);
    checkOutput("t3 ovr stays 0",   bus.ovr,  0);
    checkOutput("t3 vld",           bus.vld,  1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3 vld after ack", bus.vld, 0);

    $display("[TB] test 4: abort");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4 busy partial", bus.busy, 1);
    checkOutput("t4 abrt before",  bus.abrt, 0);
    expQ.push_back(4'hF);
    sendFrame(4'hF, 0, 0);
    checkOutput("t4 abrt set", bus.abrt, 1);
    checkOutput("t4 data",     bus.data, 4'hF);
    checkOutput("t4 vld",      bus.vld,  1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4 abrt cleared", bus.abrt, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4 set beats clr", bus.abrt, 1);
    expQ.push_back(4'h6);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4 restarted data", bus.data, 4'h6);
    checkOutput("t4 restarted busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4 abrt cleared again", bus.abrt, 0);

    $display("[TB] test 5: async reset mid-frame");
    sendFrame(4'h7, 0, 0);
    sendFrame(4'h2, 0, 0);
    checkOutput("t5 ovr before reset", bus.ovr, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5 busy before reset", bus.busy, 1);
    bus.enb = 1'b0;
    rst     = 1'b0;
    #1;
    checkOutput("t5 reset data", bus.data, 0);
    checkOutput("t5 reset vld",  bus.vld,  0);
    checkOutput("t5 reset busy", bus.busy, 0);
    checkOutput("t5 reset ovr",  bus.ovr,  0);
    checkOutput("t5 reset abrt", bus.abrt, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    expQ.push_back(4'h9);
    sendFrame(4'h9, 0, 0);
    checkOutput("t5 data after reset", bus.data, 4'h9);
    checkOutput("t5 vld after reset",  bus.vld,  1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] test 6: back-to-back loopback of all 16 values");
    loopStart = nPopped;
    for (int v = 0; v < 16; v++) begin
      expQ.push_back(4'(v));
      sendFrame(4'(v), 0, 2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6 word count", nPopped - loopStart, 16);
    checkOutput("t6 ovr",        bus.ovr,  0);
    checkOutput("t6 abrt",       bus.abrt, 0);
    checkOutput("t6 vld idle",   bus.vld,  0);
    checkOutput("queue drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
